// File: rtl/axis_arb_pkg.sv
// Shared definitions for the frame-locked AXI-Stream arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE waits for requests, XFER moves one frame)
//   rr_pick     : round-robin winner search, returns a one-hot vector
//   ARB_BUBBLE  : idle cycles between two consecutive frames
//   MAX_PORTS   : widest requester vector rr_pick can handle
package axis_arb_pkg;

   localparam int MAX_PORTS  = 16;
   localparam int ARB_BUBBLE = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   // First set bit of req searching upward from last+1, wrapping at 'ports'.
   // Zero result when req is empty. Only the low 'ports' bits of req are looked at.
   function automatic logic [MAX_PORTS-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] req,
      input logic [3:0]           last,
      input int unsigned          ports
   );
      logic [MAX_PORTS-1:0] pick;
      logic                 found;
      logic [4:0]           sum;
      logic [3:0]           sel;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
         if (i <= ports) begin
            // last < ports and i <= ports, so one subtraction is enough to wrap
            sum = {1'b0, last} + 5'(i);
            if (sum >= 5'(ports)) begin
               sum = sum - 5'(ports);
            end
            sel = sum[3:0];
            if (!found && req[sel]) begin
               pick[sel] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_frame_arbiter_if.sv
// Bundle of the arbiter's stream, configuration and status signals.
//   slave  modport : the arbiter's view (consumes s_axis_*, produces m_axis_*)
//   master modport : the environment's view (sources, FIFO sink, configuration)
// Handshake rule for both s_axis and m_axis: a beat transfers on a rising clk
// edge where tvalid and tready are both 1; a source holding tvalid=1 keeps
// tdata/tlast/tid stable until that edge, and tready may change freely.
interface axis_frame_arbiter_if #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2
) ();
   logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [PORTS-1:0]            s_axis_tvalid;
   logic [PORTS-1:0]            s_axis_tready;
   logic [PORTS-1:0]            s_axis_tlast;
   logic [DATA_WIDTH-1:0]       m_axis_tdata;
   logic                        m_axis_tvalid;
   logic                        m_axis_tready;
   logic                        m_axis_tlast;
   logic [ID_WIDTH-1:0]         m_axis_tid;
   logic [PORTS-1:0]            cfg_enable;
   logic [PORTS-1:0]            grant;
   logic                        busy;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, cfg_enable,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
             grant, busy
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, cfg_enable,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
             grant, busy
   );
endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry registered output stage for a valid/ready stream.
//   clk, rst             : clock, synchronous active-high reset (empties the stage)
//   in_data/valid/ready  : upstream side; in_ready depends only on the fill level
//   out_data/valid/ready : downstream side; out_valid/out_data come from flops
// in_ready never depends on out_ready, which breaks the combinational ready path.
module axis_skid_reg #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [1:0]       count;
   logic [WIDTH-1:0] head;   // oldest beat, presented downstream
   logic [WIDTH-1:0] tail;   // overflow beat caught while downstream stalls
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = head;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  head  <= in_data;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head <= in_data;
               end else if (push) begin
                  tail  <= in_data;
                  count <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            2'd2: begin
               // in_ready is 0 here, so only a pop can happen
               if (pop) begin
                  head  <= tail;
                  count <= 2'd1;
               end
            end
            default: count <= 2'd0;
         endcase
      end
   end
endmodule

// File: rtl/axis_frame_arbiter.sv
// Round-robin, frame-locked N:1 AXI-Stream arbiter feeding a clock-crossing FIFO.
//   clk, rst     : single clock, synchronous active-high reset
//   bus.s_axis_* : per-port packed requester streams; only the granted tready can be 1
//   bus.m_axis_* : merged stream with source index on m_axis_tid, registered via skid
//   bus.cfg_enable : per-port arbitration enable, sampled only while idle
//   bus.grant    : one-hot grant, 0 while idle
//   bus.busy     : FSM state (1 = XFER), doubles as the state debug output
// A grant is held from the first beat of a frame until its tlast beat is accepted.
module axis_frame_arbiter
   import axis_arb_pkg::*;
#(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2
) (
   input logic                   clk,
   input logic                   rst,
   axis_frame_arbiter_if.slave   bus
);
   localparam int SKID_W = ID_WIDTH + 1 + DATA_WIDTH;

   arb_state_t            state;
   logic [PORTS-1:0]      grant_r;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [PORTS-1:0]      req;
   logic [MAX_PORTS-1:0]  req_ext;
   logic [MAX_PORTS-1:0]  pick;
   logic [PORTS-1:0]      winner;
   logic [ID_WIDTH-1:0]   win_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  skid_ready;
   logic                  beat_accept;
   logic [SKID_W-1:0]     skid_out;
   logic                  skid_out_valid;

   // Winner search over enabled requesters
   always_comb begin
      req     = bus.s_axis_tvalid & bus.cfg_enable;
      req_ext = '0;
      for (int i = 0; i < PORTS; i++) begin
         req_ext[i] = req[i];
      end
      pick    = rr_pick(req_ext, 4'(last_grant), PORTS);
      winner  = '0;
      win_idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         winner[i] = pick[i];
      end
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (pick[i]) begin
            win_idx = ID_WIDTH'(i);
         end
      end
   end

   // Input mux driven by the one-hot grant
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_r[i]) begin
            sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = bus.s_axis_tvalid[i];
            sel_last  = bus.s_axis_tlast[i];
         end
      end
   end

   assign beat_accept = (state == ST_XFER) & sel_valid & skid_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant_r    <= '0;
         grant_idx  <= '0;
         last_grant <= ID_WIDTH'(PORTS - 1);  // port 0 searched first
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  grant_r   <= winner;
                  grant_idx <= win_idx;
                  state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               // cfg_enable is ignored here so a started frame always completes
               if (beat_accept && sel_last) begin
                  last_grant <= grant_idx;
                  grant_r    <= '0;
                  state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // grant_r is zero in IDLE, which keeps every tready low during arbitration
   assign bus.s_axis_tready = grant_r & {PORTS{skid_ready}};
   assign bus.grant         = grant_r;
   assign bus.busy          = (state == ST_XFER);

   axis_skid_reg #(
      .WIDTH(SKID_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({grant_idx, sel_last, sel_data}),
      .in_valid  (beat_accept),
      .in_ready  (skid_ready),
      .out_data  (skid_out),
      .out_valid (skid_out_valid),
      .out_ready (bus.m_axis_tready)
   );

   assign bus.m_axis_tvalid = skid_out_valid;
   assign bus.m_axis_tid    = skid_out[SKID_W-1 -: ID_WIDTH];
   assign bus.m_axis_tlast  = skid_out[DATA_WIDTH];
   assign bus.m_axis_tdata  = skid_out[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: per-port source queues feed the
// requesters, a scoreboard queue holds the beats expected at m_axis in order.
module tb_axis_frame_arbiter;
   import axis_arb_pkg::*;

   localparam int PORTS = 4;
   localparam int DW    = 8;
   localparam int IW    = 2;
   localparam int EW    = IW + 1 + DW;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0]    exp_q[$];           // {tid, tlast, tdata}
   logic [DW:0]      src_q[PORTS][$];    // {tlast, tdata} per port
   logic [PORTS-1:0] hold;               // force a port's tvalid low
   logic [PORTS-1:0] acc_p;              // beat accepted at the coming edge
   int               acc_cnt[PORTS];
   int               beats_out;

   axis_frame_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axis_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- input acceptance sampler ----------------
   initial begin : sampler
      acc_p = '0;
      for (int p = 0; p < PORTS; p++) acc_cnt[p] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc_p = '0;
            for (int p = 0; p < PORTS; p++) acc_cnt[p] = 0;
         end else begin
            acc_p = bus.s_axis_tvalid & bus.s_axis_tready;
            for (int p = 0; p < PORTS; p++) if (acc_p[p]) acc_cnt[p]++;
         end
      end
   end

   // ---------------- source driver ----------------
   initial begin : driver
      bus.s_axis_tvalid = '0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < PORTS; p++) begin
            if (acc_p[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0 && !hold[p]) begin
               bus.s_axis_tvalid[p]         = 1'b1;
               bus.s_axis_tdata[p*DW +: DW] = src_q[p][0][DW-1:0];
               bus.s_axis_tlast[p]          = src_q[p][0][DW];
            end else begin
               bus.s_axis_tvalid[p]         = 1'b0;
               bus.s_axis_tdata[p*DW +: DW] = '0;
               bus.s_axis_tlast[p]          = 1'b0;
            end
         end
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   initial begin : monitor
      logic [EW-1:0] got;
      logic [EW-1:0] exp;
      logic [EW-1:0] held;
      logic          held_v;
      held_v    = 1'b0;
      beats_out = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v    = 1'b0;
            beats_out = 0;
         end else begin
            got = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata};
            if (held_v) begin
               checks++;
               if (bus.m_axis_tvalid !== 1'b1 || got !== held) begin
                  errors++;
                  $display("FAIL stall_hold got valid=%0b beat=%h required valid=1 beat=%h",
                           bus.m_axis_tvalid, got, held);
               end
            end
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
               held_v = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL out_beat got %h required no beat", got);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     errors++;
                     $display("FAIL out_beat got %h required %h", got, exp);
                  end
               end
               beats_out++;
            end else if (bus.m_axis_tvalid === 1'b1) begin
               held_v = 1'b1;
               held   = got;
            end else begin
               held_v = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_src(input int p, input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) src_q[p].push_back({(i == n - 1), base + DW'(i)});
   endtask

   task automatic push_exp(input int p, input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({IW'(p), (i == n - 1), base + DW'(i)});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < PORTS; p++) src_q[p].delete();
      exp_q.delete();
      hold              = '0;
      bus.cfg_enable    = '1;
      bus.m_axis_tready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_acc(input int p, input int n, input int budget, input string name);
      int c;
      c = 0;
      while (acc_cnt[p] < n && c < budget) begin
         step();
         c++;
      end
      checks++;
      if (acc_cnt[p] < n) begin
         errors++;
         $display("FAIL %s accepted=%0d required>=%0d (timeout)", name, acc_cnt[p], n);
      end
   endtask

   task automatic wait_out(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (beats_out < n && c < budget) begin
         step();
         c++;
      end
      checks++;
      if (beats_out < n) begin
         errors++;
         $display("FAIL %s beats_out=%0d required>=%0d (timeout)", name, beats_out, n);
      end
   endtask

   task automatic wait_drain(input int budget, input string name);
      int c;
      int pend;
      c = 0;
      pend = exp_q.size();
      for (int p = 0; p < PORTS; p++) pend += src_q[p].size();
      while (pend > 0 && c < budget) begin
         step();
         c++;
         pend = exp_q.size();
         for (int p = 0; p < PORTS; p++) pend += src_q[p].size();
      end
      checks++;
      if (pend > 0) begin
         errors++;
         $display("FAIL %s_drain pending=%0d required 0", name, pend);
      end
      step();
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.m_axis_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle busy=%0b grant=%b m_valid=%0b required 0 0000 0",
                  name, bus.busy, bus.grant, bus.m_axis_tvalid);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_fsm grant=%b busy=%0b required 0000 0", bus.grant, bus.busy);
      end
      checks++;
      if (bus.s_axis_tready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_tready got %b required 0000", bus.s_axis_tready);
      end
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 8'h00 ||
          bus.m_axis_tid !== 2'd0 || bus.m_axis_tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_m_axis valid=%0b data=%h tid=%0d last=%0b required all 0",
                  bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast);
      end
   endtask

   task automatic test_two_ports();
      do_reset();
      push_src(0, 8'hA0, 3);
      push_src(2, 8'hC0, 3);
      push_exp(0, 8'hA0, 3);
      push_exp(2, 8'hC0, 3);
      step();  // sources present after this edge
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL lat_grant_early got %b required 0000", bus.grant);
      end
      step();  // request seen by IDLE
      checks++;
      if (bus.grant !== 4'b0001 || bus.s_axis_tready !== 4'b0001 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL lat_grant grant=%b tready=%b busy=%0b required 0001 0001 1",
                  bus.grant, bus.s_axis_tready, bus.busy);
      end
      step();  // first beat accepted
      checks++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'hA0 || bus.m_axis_tid !== 2'd0) begin
         errors++;
         $display("FAIL lat_first_beat valid=%0b data=%h tid=%0d required 1 a0 0",
                  bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid);
      end
      wait_drain(100, "two_ports");
   endtask

   task automatic test_all_ports();
      logic [3:0] prev;
      logic [3:0] exp_g;
      int         gap;
      int         seen;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < PORTS; p++) begin
            push_src(p, 8'(8'h50 + 16 * p + r), 1);
            push_exp(p, 8'(8'h50 + 16 * p + r), 1);
         end
      end
      prev = 4'b0000;
      gap  = 0;
      seen = 0;
      for (int c = 0; c < 80 && seen < 8; c++) begin
         step();
         if (bus.grant !== 4'b0000) begin
            if (prev === 4'b0000) begin
               if (seen > 0) begin
                  checks++;
                  if (gap != ARB_BUBBLE) begin
                     errors++;
                     $display("FAIL rr_gap got %0d required %0d", gap, ARB_BUBBLE);
                  end
               end
               exp_g = 4'b0001 << (seen % 4);
               checks++;
               if (bus.grant !== exp_g) begin
                  errors++;
                  $display("FAIL rr_grant got %b required %b", bus.grant, exp_g);
               end
               seen++;
            end else begin
               checks++;
               errors++;
               $display("FAIL rr_hold grant=%b held 2 cycles required 1", bus.grant);
            end
            gap = 0;
         end else begin
            gap++;
         end
         prev = bus.grant;
      end
      checks++;
      if (seen != 8) begin
         errors++;
         $display("FAIL rr_count got %0d required 8", seen);
      end
      wait_drain(100, "all_ports");
   endtask

   task automatic test_disable_mid_frame();
      logic bad;
      do_reset();
      push_src(1, 8'hB0, 4);
      push_src(1, 8'hB8, 1);
      push_src(3, 8'hD0, 2);
      push_exp(1, 8'hB0, 4);
      push_exp(3, 8'hD0, 2);
      push_exp(1, 8'hB8, 1);
      wait_acc(1, 2, 50, "dis_mid");
      bus.cfg_enable = 4'b1101;
      wait_acc(1, 4, 50, "dis_rest");
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.grant[1] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL dis_no_grant grant[1] seen=1 required 0");
      end
      checks++;
      if (acc_cnt[3] != 2) begin
         errors++;
         $display("FAIL dis_other_port accepted=%0d required 2", acc_cnt[3]);
      end
      bus.cfg_enable = 4'b1111;
      wait_drain(100, "disable");
   endtask

   task automatic test_backpressure();
      int base;
      do_reset();
      push_src(2, 8'h20, 6);
      push_exp(2, 8'h20, 6);
      wait_out(1, 50, "bp_start");
      bus.m_axis_tready = 1'b0;
      base = acc_cnt[2];
      for (int c = 0; c < 10; c++) step();
      checks++;
      if (acc_cnt[2] - base > 2) begin
         errors++;
         $display("FAIL bp_accepted got %0d required <=2", acc_cnt[2] - base);
      end
      checks++;
      if (bus.s_axis_tready[2] !== 1'b0 || bus.m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready tready2=%0b m_valid=%0b required 0 1",
                  bus.s_axis_tready[2], bus.m_axis_tvalid);
      end
      bus.m_axis_tready = 1'b1;
      wait_drain(100, "backpressure");
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      push_src(0, 8'h01, 1);
      push_src(1, 8'h10, 6);
      push_exp(0, 8'h01, 1);
      push_exp(1, 8'h10, 6);
      wait_out(3, 50, "rst_mid");
      rst = 1'b1;
      for (int p = 0; p < PORTS; p++) src_q[p].delete();
      exp_q.delete();
      step();
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.s_axis_tready !== 4'b0000) begin
         errors++;
         $display("FAIL rst_mid_fsm grant=%b busy=%0b tready=%b required 0000 0 0000",
                  bus.grant, bus.busy, bus.s_axis_tready);
      end
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 8'h00 ||
          bus.m_axis_tid !== 2'd0 || bus.m_axis_tlast !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_m_axis valid=%0b data=%h tid=%0d last=%0b required all 0",
                  bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast);
      end
      rst = 1'b0;
      push_src(3, 8'h70, 2);
      push_src(0, 8'h08, 2);
      push_exp(0, 8'h08, 2);
      push_exp(3, 8'h70, 2);
      step();
      step();
      checks++;
      if (bus.grant !== 4'b0001) begin
         errors++;
         $display("FAIL rst_first_winner got %b required 0001", bus.grant);
      end
      wait_drain(100, "rst_mid");
   endtask

   task automatic test_stall_valid();
      logic bad;
      do_reset();
      push_src(3, 8'h30, 6);
      push_exp(3, 8'h30, 6);
      wait_acc(3, 2, 50, "stall_mid");
      hold[3] = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (bus.grant !== 4'b1000 || bus.busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_grant grant=%b busy=%0b required 1000 1", bus.grant, bus.busy);
      end
      hold[3] = 1'b0;
      wait_drain(100, "stall_valid");
   endtask

   // ---------------- sequence and report ----------------
   initial begin : main
      rst               = 1'b1;
      hold              = '0;
      bus.cfg_enable    = '1;
      bus.m_axis_tready = 1'b1;
      test_reset();
      test_two_ports();
      test_all_ports();
      test_disable_mid_frame();
      test_backpressure();
      test_reset_mid_frame();
      test_stall_valid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
